// File: rtl/notch_pkg.sv
// Shared definitions for the notch-filter front end.
//   DataSizeDefault : default sample width of the audio path
//   rx_state_e      : I2S receiver FSM encoding (idle / shifting a word / word complete)
package notch_pkg;

  localparam int unsigned DataSizeDefault = 24;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } rx_state_e;

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchroniser for a single asynchronous input bit.
// Ports:
//   clk   - destination clock
//   reset - asynchronous active-high reset, clears every stage to 0
//   d_i   - asynchronous input
//   q_o   - synchronised output, SYNC_STAGES clk cycles behind d_i
module sync_ff #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d_i};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/i2s_sample_rx.sv
// I2S left-channel receiver feeding a notch filter.
// Captures the left-channel word of each I2S frame (MSB first, one-bit delay after
// ws falls) and hands it to the filter with a one-cycle sample pulse, provided the
// filter is idle. Right-channel words are never delivered.
// Ports:
//   clk         - system clock, the only clock domain
//   reset       - asynchronous active-high reset
//   sck, ws, sd - I2S bit clock, word select (0 = left), serial data; asynchronous
//   data_out    - last accepted left sample
//   sample      - one-clk pulse: data_out just updated
//   filter_done - filter completion pulse, frees the filter for the next word
//   overrun     - sticky: a word completed while the filter was still busy
//   frame_err   - sticky: a left word was cut short by ws rising
module i2s_sample_rx
  import notch_pkg::*;
#(
  parameter int unsigned DATA_SIZE   = DataSizeDefault,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sck,
  input  logic                 ws,
  input  logic                 sd,
  output logic [DATA_SIZE-1:0] data_out,
  output logic                 sample,
  input  logic                 filter_done,
  output logic                 overrun,
  output logic                 frame_err
);

  localparam int unsigned CntW = $clog2(DATA_SIZE + 1);
  localparam logic [CntW-1:0] CntFull = CntW'(DATA_SIZE);

  // Synchronised pins
  logic sck_s;
  logic ws_s;
  logic sd_s;

  sync_ff #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_sck (
    .clk  (clk),
    .reset(reset),
    .d_i  (sck),
    .q_o  (sck_s)
  );

  sync_ff #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_ws (
    .clk  (clk),
    .reset(reset),
    .d_i  (ws),
    .q_o  (ws_s)
  );

  sync_ff #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_sd (
    .clk  (clk),
    .reset(reset),
    .d_i  (sd),
    .q_o  (sd_s)
  );

  // State
  rx_state_e            state_q, state_d;
  logic [CntW-1:0]      bit_cnt_q, bit_cnt_d;
  logic [DATA_SIZE-1:0] shift_q, shift_d;
  logic                 ws_prev_q, ws_prev_d;
  logic                 armed_q, armed_d;
  logic                 busy_q, busy_d;
  logic [DATA_SIZE-1:0] data_out_q, data_out_d;
  logic                 sample_q, sample_d;
  logic                 overrun_q, overrun_d;
  logic                 frame_err_q, frame_err_d;

  // One register stage after the synchronisers: the edge detector compares this stage
  // with the one behind it, and ws/sd are taken from the same stage so they stay
  // aligned with the detected rise. This sets the fixed pin-to-sample latency.
  logic sck_dly_q, sck_dly_d;
  logic sck_prev_q, sck_prev_d;
  logic ws_dly_q, ws_dly_d;
  logic sd_dly_q, sd_dly_d;

  logic            sck_rise;
  logic [CntW-1:0] bit_cnt_inc;

  assign sck_rise    = sck_dly_q & ~sck_prev_q;
  assign bit_cnt_inc = bit_cnt_q + CntW'(1);

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    ws_prev_d   = ws_prev_q;
    armed_d     = armed_q;
    busy_d      = busy_q;
    data_out_d  = data_out_q;
    sample_d    = 1'b0;
    overrun_d   = overrun_q;
    frame_err_d = frame_err_q;

    sck_dly_d  = sck_s;
    sck_prev_d = sck_dly_q;
    ws_dly_d   = ws_s;
    sd_dly_d   = sd_s;

    // ws_prev starts at 1 out of reset, so a ws that is already low at release would
    // look like a fresh 1->0 edge. armed blocks that until ws has really been seen high.
    if (sck_rise) begin
      ws_prev_d = ws_dly_q;
      if (ws_dly_q) begin
        armed_d = 1'b1;
      end
    end

    // Done is applied before any accept below, so a coincident accept re-sets busy.
    if (filter_done) begin
      busy_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        // sd on the starting rise is the one-bit I2S delay slot and is ignored.
        if (sck_rise && armed_q && ws_prev_q && !ws_dly_q) begin
          state_d   = StShift;
          bit_cnt_d = '0;
        end
      end

      StShift: begin
        if (sck_rise) begin
          // ws may legitimately rise on the LSB rise of a full-length slot, so only a
          // rise that would not complete the word counts as a truncation.
          if (ws_dly_q && (bit_cnt_inc != CntFull)) begin
            state_d     = StIdle;
            bit_cnt_d   = '0;
            frame_err_d = 1'b1;
          end else begin
            shift_d   = {shift_q[DATA_SIZE-2:0], sd_dly_q};
            bit_cnt_d = bit_cnt_inc;
            if (bit_cnt_inc == CntFull) begin
              state_d = StDone;
            end
          end
        end
      end

      StDone: begin
        state_d = StIdle;
        if (!busy_q || filter_done) begin
          data_out_d = shift_q;
          sample_d   = 1'b1;
          busy_d     = 1'b1;
        end else begin
          overrun_d = 1'b1;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      ws_prev_q   <= 1'b1;
      armed_q     <= 1'b0;
      busy_q      <= 1'b0;
      data_out_q  <= '0;
      sample_q    <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
      sck_dly_q   <= 1'b0;
      sck_prev_q  <= 1'b0;
      ws_dly_q    <= 1'b0;
      sd_dly_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      ws_prev_q   <= ws_prev_d;
      armed_q     <= armed_d;
      busy_q      <= busy_d;
      data_out_q  <= data_out_d;
      sample_q    <= sample_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
      sck_dly_q   <= sck_dly_d;
      sck_prev_q  <= sck_prev_d;
      ws_dly_q    <= ws_dly_d;
      sd_dly_q    <= sd_dly_d;
    end
  end

  assign data_out  = data_out_q;
  assign sample    = sample_q;
  assign overrun   = overrun_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_i2s_sample_rx.sv
// Self-checking bench for i2s_sample_rx: drives I2S frames, pushes expected left words
// to a scoreboard queue and compares them whenever the DUT pulses sample.
module tb_i2s_sample_rx;

  localparam int unsigned DW   = 24;
  localparam int unsigned SS   = 2;
  localparam int          HALF = 6;  // clk cycles per sck half-period

  logic          clk;
  logic          reset;
  logic          sck;
  logic          ws;
  logic          sd;
  logic [DW-1:0] data_out;
  logic          sample;
  logic          filter_done;
  logic          overrun;
  logic          frame_err;

  i2s_sample_rx #(
    .DATA_SIZE  (DW),
    .SYNC_STAGES(SS)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .sck        (sck),
    .ws         (ws),
    .sd         (sd),
    .data_out   (data_out),
    .sample     (sample),
    .filter_done(filter_done),
    .overrun    (overrun),
    .frame_err  (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad = 0;
  int n_samples = 0;
  logic [DW-1:0] exp_q[$];
  logic carry = 1'b0;
  logic pulse_on_lsb = 1'b0;
  logic measure_lat = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Scoreboard side: every sample pulse must match the oldest pending word.
  always @(negedge clk) begin
    if (!reset && sample === 1'b1) begin
      n_samples++;
      if (exp_q.size() == 0) begin
        check_val("unexpected_sample", 32'(data_out), 32'hDEAD_BEEF);
      end else begin
        check_val("data_out", 32'(data_out), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check_outputs_zero(input string tag);
    check_val({tag, "_data"}, 32'(data_out), 32'h0);
    check_val({tag, "_sample"}, 32'(sample), 32'h0);
    check_val({tag, "_overrun"}, 32'(overrun), 32'h0);
    check_val({tag, "_frame_err"}, 32'(frame_err), 32'h0);
  endtask

  // One sck period: falling half with new ws/sd, then the rising half.
  task automatic do_rise(input logic w, input logic d, input logic lsb);
    int lat;
    sck = 1'b0;
    ws  = w;
    sd  = d;
    repeat (HALF) @(posedge clk);
    #1 sck = 1'b1;
    lat = -1;
    for (int i = 1; i <= HALF; i++) begin
      @(posedge clk);
      #1;
      if (lsb && pulse_on_lsb) filter_done = (i == 4);
      if (lat < 0 && sample === 1'b1) lat = i;
    end
    if (lsb && measure_lat) check_val("latency", 32'(lat), 32'(SS + 3));
  endtask

  // Full I2S frame (left slot then right slot, each `slot` sck long).
  // abort_at >= 0 forces ws high from that rise; rst_at >= 0 pulses reset before that rise.
  task automatic send_frame(input logic [DW-1:0] l, input logic [DW-1:0] r, input int slot,
                            input logic fill, input bit push, input int abort_at,
                            input int rst_at);
    logic [DW-1:0] wd;
    logic b;
    logic w;
    int p;
    int pos;
    if (push) exp_q.push_back(l);
    for (int k = 0; k < 2 * slot; k++) begin
      if (k == rst_at) begin
        reset = 1'b1;
        #2;
        check_outputs_zero("midword_reset");
        @(posedge clk);
        #1 reset = 1'b0;
      end
      if (k == 0) begin
        b = carry;
      end else begin
        p   = k - 1;
        wd  = (p < slot) ? l : r;
        pos = p % slot;
        b   = (pos < DW) ? wd[DW-1-pos] : fill;
      end
      w = (k >= slot) || (abort_at >= 0 && k >= abort_at);
      do_rise(w, b, k == DW);
    end
    pos   = (2 * slot - 1) % slot;
    wd    = r;
    carry = (pos < DW) ? wd[DW-1-pos] : fill;
  endtask

  task automatic pulse_done();
    @(posedge clk);
    #1 filter_done = 1'b1;
    @(posedge clk);
    #1 filter_done = 1'b0;
  endtask

  task automatic preamble();
    do_rise(1'b1, 1'b0, 1'b0);
    do_rise(1'b1, 1'b0, 1'b0);
    carry = 1'b0;
  endtask

  initial begin
    int n0;
    reset       = 1'b1;
    sck         = 1'b0;
    ws          = 1'b1;
    sd          = 1'b0;
    filter_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    reset = 1'b0;
    preamble();

    // Left 800001 / right 7FFFFF, idle filter
    n0 = n_samples;
    send_frame(24'h800001, 24'h7FFFFF, DW, 1'b0, 1'b1, -1, -1);
    repeat (10) @(posedge clk);
    #1;
    check_val("t1_count", 32'(n_samples - n0), 32'd1);
    check_val("t1_data", 32'(data_out), 32'h800001);
    check_val("t1_overrun", 32'(overrun), 32'h0);
    check_val("t1_frame_err", 32'(frame_err), 32'h0);

    // filter_done on the exact DONE cycle while busy
    n0 = n_samples;
    pulse_on_lsb = 1'b1;
    send_frame(24'h000F0F, 24'h000000, DW, 1'b0, 1'b1, -1, -1);
    pulse_on_lsb = 1'b0;
    check_val("t3_count", 32'(n_samples - n0), 32'd1);
    check_val("t3_data", 32'(data_out), 32'h000F0F);
    check_val("t3_overrun", 32'(overrun), 32'h0);

    // Two frames, filter never completes the first
    pulse_done();
    n0 = n_samples;
    send_frame(24'h123456, 24'h000000, DW, 1'b0, 1'b1, -1, -1);
    send_frame(24'hABCDEF, 24'h000000, DW, 1'b0, 1'b0, -1, -1);
    check_val("t2_count", 32'(n_samples - n0), 32'd1);
    check_val("t2_data", 32'(data_out), 32'h123456);
    check_val("t2_overrun", 32'(overrun), 32'h1);

    // Reset clears the sticky flags asynchronously
    reset = 1'b1;
    #2;
    check_outputs_zero("async_reset");
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    preamble();

    // ws rises after 10 left bits, then a normal frame
    n0 = n_samples;
    send_frame(24'hA5A5A5, 24'h000000, DW, 1'b0, 1'b0, 11, -1);
    check_val("t4_frame_err", 32'(frame_err), 32'h1);
    check_val("t4_count", 32'(n_samples - n0), 32'd0);
    send_frame(24'h55AA55, 24'h000000, DW, 1'b0, 1'b1, -1, -1);
    check_val("t4b_count", 32'(n_samples - n0), 32'd1);
    check_val("t4b_data", 32'(data_out), 32'h55AA55);

    // Reset after 12 bits of a word; partial word must never appear
    n0 = n_samples;
    send_frame(24'hFEDCBA, 24'h000000, DW, 1'b0, 1'b0, -1, 13);
    check_val("t5_partial_count", 32'(n_samples - n0), 32'd0);
    send_frame(24'h000001, 24'h000000, DW, 1'b0, 1'b1, -1, -1);
    check_val("t5_count", 32'(n_samples - n0), 32'd1);
    check_val("t5_data", 32'(data_out), 32'h000001);

    // 32-bit slot with trailing ones, latency measured on the LSB rise
    pulse_done();
    measure_lat = 1'b1;
    send_frame(24'hC0FFEE, 24'h000000, 32, 1'b1, 1'b1, -1, -1);
    measure_lat = 1'b0;
    check_val("t6_data", 32'(data_out), 32'hC0FFEE);
    check_val("t6_overrun", 32'(overrun), 32'h0);

    repeat (10) @(posedge clk);
    check_val("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/i2s_sample_rx.md
I2S_SAMPLE_RX -- requirements
Module: i2s_sample_rx

Interface
REQ-001 The module SHALL have parameter DATA_SIZE, default 24, giving the sample width in bits.
REQ-002 The module SHALL have parameter SYNC_STAGES, default 2, giving the flip-flop count of each input synchroniser (minimum 2).
REQ-003 Port clk SHALL be an input, 1 bit wide: the system clock; all logic runs in this one clock domain.
REQ-004 Port reset SHALL be an input, 1 bit wide: asynchronous, active-high reset.
REQ-005 Port sck SHALL be an input, 1 bit wide: I2S bit clock, asynchronous to clk, with each half-period at least 4 clk cycles.
REQ-006 Port ws SHALL be an input, 1 bit wide: I2S word select; 0 selects the left channel.
REQ-007 Port sd SHALL be an input, 1 bit wide: I2S serial data, MSB first, two's complement.
REQ-008 Port data_out SHALL be an output, DATA_SIZE bits wide: the last accepted left-channel sample, feeding the notch filter's data_in.
REQ-009 Port sample SHALL be an output, 1 bit wide: a one-clk pulse marking data_out as new, feeding the filter's sample_trig.
REQ-010 Port filter_done SHALL be an input, 1 bit wide: the filter's completion pulse.
REQ-011 Port overrun SHALL be an output, 1 bit wide: sticky flag, set when a word completes while the filter is busy.
REQ-012 Port frame_err SHALL be an output, 1 bit wide: sticky flag, set when a left word is truncated by ws rising.

Function
REQ-013 sck, ws and sd SHALL each pass through a SYNC_STAGES-deep synchroniser; an sck rise is the cycle where the synchronised sck goes 0->1.
REQ-014 ws and sd SHALL be sampled only on sck-rise cycles; ws_prev holds ws from the previous rise.
REQ-015 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-016 In IDLE, an sck rise with ws_prev=1 and ws=0 SHALL move the FSM to SHIFT with bit_cnt=0; sd at this rise is ignored (one-bit I2S delay).
REQ-017 In SHIFT, each sck rise SHALL shift sd into the LSB of shift_reg and increment bit_cnt.
REQ-018 The rise that brings bit_cnt to DATA_SIZE SHALL move the FSM to DONE.
REQ-019 Bits beyond DATA_SIZE in a longer slot SHALL be ignored.
REQ-020 In SHIFT, an sck rise with ws=1 before DATA_SIZE bits SHALL abort to IDLE, set frame_err and leave data_out unchanged.
REQ-021 DONE SHALL last exactly one clk cycle, then the FSM returns to IDLE.
REQ-022 In DONE with busy=0: data_out<=shift_reg, sample=1 in the next cycle, and busy<=1.
REQ-023 In DONE with busy=1: the word is dropped, data_out and sample are unchanged, and overrun is set.
REQ-024 busy SHALL be cleared by filter_done=1.
REQ-025 If filter_done and DONE coincide, the word SHALL be accepted: done clears busy first, then the accept sets it.
REQ-026 The right channel (ws=1) SHALL never produce sample.
REQ-027 Latency SHALL be fixed: sample asserts SYNC_STAGES+3 clk cycles after the pin-level sck rise carrying the LSB.
REQ-028 bit_cnt SHALL be $clog2(DATA_SIZE+1) bits wide and SHALL NOT wrap.
REQ-029 overrun and frame_err SHALL clear only on reset.

Reset
REQ-030 While reset=1, the outputs SHALL be held at: data_out=0, sample=0, overrun=0, frame_err=0.
REQ-031 While reset=1, internal state SHALL be held at: FSM=IDLE, busy=0, bit_cnt=0, shift_reg=0, ws_prev=1, synchronisers=0.
REQ-032 Reset asserted mid-word SHALL discard the partial word.
REQ-033 After reset release, reception SHALL start only at the next fresh ws 1->0 transition.

Structure
REQ-034 Shared package notch_pkg SHALL hold the DATA_SIZE default and the FSM state encoding (IDLE/SHIFT/DONE).
REQ-035 The synchroniser SHALL be one sub-module, sync_ff (parameter SYNC_STAGES), instantiated three times; there is no other hierarchy.

Verification
REQ-036 Bench: left word 24'h800001, right word 24'h7FFFFF, idle filter -> one sample pulse, data_out=24'h800001, flags 0.
REQ-037 Bench: two frames, 24'h123456 then 24'hABCDEF, filter_done held low -> first word accepted, second dropped, data_out=24'h123456, overrun=1.
REQ-038 Bench: filter_done pulsed on the exact DONE cycle of word 24'h000F0F -> word accepted, sample pulses, overrun=0.
REQ-039 Bench: ws rises after 10 left bits -> frame_err=1, no sample, next full frame 24'h55AA55 received normally.
REQ-040 Bench: reset asserted after 12 bits of a word -> all outputs 0 asynchronously; after release the partial word is never output and the following frame 24'h000001 is output.
REQ-041 Bench: 32-bit slot with 24'hC0FFEE followed by 8 ones -> data_out=24'hC0FFEE, latency exactly SYNC_STAGES+3 cycles.
